radix2_butterfly_pipe: RTL and testbench
========================================

RADIX2_BUTTERFLY_PIPE -- requirements
Module: radix2_butterfly_pipe

Interface
REQ-001 SHALL have parameter LOGQ, default 17, operand/result width in bits.
REQ-002 SHALL have parameter Q, default 65537, modulus.
REQ-003 SHALL have parameter TWOINV, default 32769, 2^-1 mod Q.
REQ-004 SHALL have parameter TAGW, default 8, width of the sideband tag carried with each operation.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-008 SHALL have port in_valid, input, 1, input operation present.
REQ-009 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-010 SHALL have port mode, input, 1: 0 = DIF (Gentleman-Sande), 1 = DIT (Cooley-Tukey).
REQ-011 SHALL have port scale, input, 1, multiply both results by TWOINV (inverse-NTT step).
REQ-012 SHALL have ports a0, a1 and tf, each input, LOGQ, unsigned residues in [0, Q-1].
REQ-013 SHALL have port tag_in, input, TAGW, sideband data.
REQ-014 SHALL have port out_valid, output, 1, result present.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-016 SHALL have ports A0 and A1, each output, LOGQ, results in [0, Q-1].
REQ-017 SHALL have port tag_out, output, TAGW, tag_in of the same operation.

Function
REQ-018 Transfer SHALL occur on in_valid&in_ready (input) and on out_valid&out_ready (output).
REQ-019 In DIF, A0 SHALL equal (a0+a1) mod Q and A1 SHALL equal ((a0-a1) mod Q)*tf mod Q.
REQ-020 In DIT, with t = a1*tf mod Q, A0 SHALL equal (a0+t) mod Q and A1 SHALL equal (a0-t) mod Q.
REQ-021 When scale=1 and the scaling feature is built, both results SHALL additionally be multiplied by TWOINV mod Q.
REQ-022 All intermediates SHALL be unsigned, wide enough that no overflow occurs; subtraction SHALL add Q on borrow, never go negative.
REQ-023 Latency SHALL be exactly 4 cycles from input transfer to out_valid, in both modes and with either scale value, when there is no stall.
REQ-024 Pipeline SHALL advance when adv = !out_valid | out_ready; in_ready SHALL equal adv, combinationally.
REQ-025 While adv=0, all stage registers (data, mode, scale, tag, valid bits) SHALL hold; no operation SHALL be lost, duplicated or reordered.
REQ-026 Full throughput SHALL be one operation per cycle; bubbles (in_valid=0) SHALL propagate as invalid stages.
REQ-027 mode, scale and tag SHALL be sampled with the operands, so mixed-mode back-to-back streams are correct.
REQ-028 Out-of-range inputs (at least Q) SHALL give unspecified results but SHALL not affect the handshake.

Reset
REQ-029 On rst, all stage valid bits SHALL clear immediately, so out_valid=0 and in_ready=1 after reset.
REQ-030 On rst, A0, A1 and tag_out SHALL be 0; in-flight operations SHALL be discarded; rst mid-stall SHALL also clear the stall.

Configuration
REQ-031 Macro RADIX2_BUTTERFLY_SCALE_EN SHALL, when defined, build the TWOINV scaling multipliers.
REQ-032 Without RADIX2_BUTTERFLY_SCALE_EN, scale SHALL be ignored; outputs SHALL be unscaled with unchanged 4-cycle latency, via a register stage in place of the multipliers.

Structure
REQ-033 Package ntt_pkg SHALL hold the default LOGQ/Q/TWOINV constants, the mode encodings (MODE_DIF=0, MODE_DIT=1) and the latency constant BFLY_LAT=4.
REQ-034 Modular multiplication SHALL be a sub-module modq_mul_reg (product mod Q, one register stage, with hold-enable), instantiated for the twiddle product and, when built, for scaling.

Verification
REQ-035 DIF case: a0=5, a1=3, tf=2, scale=0 -> A0=8, A1=4 exactly 4 cycles later.
REQ-036 DIF borrow case: a0=3, a1=5, tf=1 -> A0=8, A1=65535.
REQ-037 DIT case: a0=10, a1=65536, tf=65536 -> t=1, A0=11, A1=9.
REQ-038 Scale case (macro defined): DIF a0=1, a1=1, tf=1, scale=1 -> A0=1, A1=0; without the macro -> A0=2, A1=0.
REQ-039 Stall case: 10 back-to-back ops with tags 0..9 and out_ready low for cycles 6-8 -> in_ready low while out_valid is held, all 10 results delivered once, in tag order.
REQ-040 Reset case: assert rst with 3 ops in flight -> out_valid=0 and outputs 0 immediately, in_ready=1, no stale result afterwards.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants for the NTT butterfly datapath: default field parameters,
// butterfly mode encodings and the fixed pipeline latency.
package ntt_pkg;

    localparam int DEF_LOGQ   = 17;
    localparam int DEF_Q      = 65537;
    localparam int DEF_TWOINV = 32769;
    localparam int BFLY_LAT   = 4;

    typedef enum logic {
        MODE_DIF = 1'b0,
        MODE_DIT = 1'b1
    } bfly_mode_e;

endpackage

// File: rtl/modq_mul_reg.sv
// Registered modular multiplier: p <= (a*b) mod Q whenever en is high, else holds.
module modq_mul_reg
    import ntt_pkg::*;
#(
    parameter int LOGQ = DEF_LOGQ,
    parameter int Q    = DEF_Q
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] b,
    output logic [LOGQ-1:0] p
);

    localparam logic [2*LOGQ-1:0] QW = (2*LOGQ)'(Q);

    logic [2*LOGQ-1:0] prod;
    logic [LOGQ-1:0]   res;

    // Full-width product, so the reduction never sees a truncated value.
    assign prod = {{LOGQ{1'b0}}, a} * {{LOGQ{1'b0}}, b};
    assign res  = LOGQ'(prod % QW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else if (en) begin
            p <= res;
        end
    end

endmodule

// File: rtl/radix2_butterfly_pipe.sv
// Four-stage modular radix-2 butterfly (DIF or DIT per operation) with a
// ready/valid stall. Optional TWOINV scaling is built with RADIX2_BUTTERFLY_SCALE_EN.
module radix2_butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int LOGQ   = DEF_LOGQ,
    parameter int Q      = DEF_Q,
    parameter int TWOINV = DEF_TWOINV,
    parameter int TAGW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode,
    input  logic            scale,
    input  logic [LOGQ-1:0] a0,
    input  logic [LOGQ-1:0] a1,
    input  logic [LOGQ-1:0] tf,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] A0,
    output logic [LOGQ-1:0] A1,
    output logic [TAGW-1:0] tag_out
);

    localparam logic [LOGQ:0] QX = (LOGQ+1)'(Q);

    function automatic logic [LOGQ-1:0] add_mod(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y);
        logic [LOGQ:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return LOGQ'(s);
    endfunction

    // Borrow is resolved by adding Q before subtracting, so nothing goes negative.
    function automatic logic [LOGQ-1:0] sub_mod(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y);
        logic [LOGQ:0] d;
        if (x >= y) d = {1'b0, x} - {1'b0, y};
        else        d = {1'b0, x} + QX - {1'b0, y};
        return LOGQ'(d);
    endfunction

    logic                adv;
    logic [BFLY_LAT-1:0] vld;
    logic [TAGW-1:0]     tag_pipe [BFLY_LAT];
    bfly_mode_e          mode_in, mode1, mode2;
    logic                scale1, scale2, scale3;
    logic [LOGQ-1:0]     x1, y1, tf1, x2, p2, r0, r1, k3;

    assign adv       = !vld[BFLY_LAT-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[BFLY_LAT-1];
    assign tag_out   = tag_pipe[BFLY_LAT-1];
    assign mode_in   = bfly_mode_e'(mode);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's pre-edge value; blocking here would collapse stages.
    // NOTE: data and tag registers are reset too, because A0/A1/tag_out must read 0
    // straight out of reset; this is a handful of flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < BFLY_LAT; i++) tag_pipe[i] <= '0;
        end else if (adv) begin
            vld         <= {vld[BFLY_LAT-2:0], in_valid};
            tag_pipe[0] <= tag_in;
            for (int i = 1; i < BFLY_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    // Stage 1: DIF does its add/sub up front; DIT passes operands to the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode1  <= MODE_DIF;
            scale1 <= 1'b0;
            tf1    <= '0;
            x1     <= '0;
            y1     <= '0;
        end else if (adv) begin
            mode1  <= mode_in;
            scale1 <= scale;
            tf1    <= tf;
            if (mode_in == MODE_DIT) begin
                x1 <= a0;
                y1 <= a1;
            end else begin
                x1 <= add_mod(a0, a1);
                y1 <= sub_mod(a0, a1);
            end
        end
    end

    // Stage 2: twiddle product.
    modq_mul_reg #(.LOGQ(LOGQ), .Q(Q)) u_tw_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .a   (y1),
        .b   (tf1),
        .p   (p2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode2  <= MODE_DIF;
            scale2 <= 1'b0;
            x2     <= '0;
        end else if (adv) begin
            mode2  <= mode1;
            scale2 <= scale1;
            x2     <= x1;
        end
    end

    // Stage 3: DIT add/sub on the twiddled operand; DIF results are already final.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale3 <= 1'b0;
            r0     <= '0;
            r1     <= '0;
        end else if (adv) begin
            scale3 <= scale2;
            if (mode2 == MODE_DIT) begin
                r0 <= add_mod(x2, p2);
                r1 <= sub_mod(x2, p2);
            end else begin
                r0 <= x2;
                r1 <= p2;
            end
        end
    end

    assign k3 = scale3 ? LOGQ'(TWOINV) : LOGQ'(1);

    // Stage 4: optional scaling by TWOINV; multiplying by 1 keeps unscaled ops exact.
`ifdef RADIX2_BUTTERFLY_SCALE_EN
    modq_mul_reg #(.LOGQ(LOGQ), .Q(Q)) u_scale0_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .a   (r0),
        .b   (k3),
        .p   (A0)
    );

    modq_mul_reg #(.LOGQ(LOGQ), .Q(Q)) u_scale1_mul (
        .clk (clk),
        .rst (rst),
        .en  (adv),
        .a   (r1),
        .b   (k3),
        .p   (A1)
    );
`else
    logic unused_k;
    assign unused_k = ^k3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A0 <= '0;
            A1 <= '0;
        end else if (adv) begin
            A0 <= r0;
            A1 <= r1;
        end
    end
`endif

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Directed bench for radix2_butterfly_pipe: reset, DIF/DIT arithmetic, scaling,
// stalled back-to-back stream with bubbles, and reset with operations in flight.
module tb_radix2_butterfly_pipe;
    import ntt_pkg::*;

    localparam int LOGQ = 17;
    localparam int TAGW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            mode = 1'b0;
    logic            scale = 1'b0;
    logic [LOGQ-1:0] a0 = '0;
    logic [LOGQ-1:0] a1 = '0;
    logic [LOGQ-1:0] tf = '0;
    logic [TAGW-1:0] tag_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [LOGQ-1:0] A0;
    logic [LOGQ-1:0] A1;
    logic [TAGW-1:0] tag_out;

    int n_checks = 0;
    int n_pass   = 0;

    radix2_butterfly_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .scale     (scale),
        .a0        (a0),
        .a1        (a1),
        .tf        (tf),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A0        (A0),
        .A1        (A1),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Present one op for one cycle, then count negedges until out_valid (bounded).
    task automatic send_and_wait(input logic m, input logic s, input logic [LOGQ-1:0] x0,
                                 input logic [LOGQ-1:0] x1, input logic [LOGQ-1:0] t,
                                 input logic [TAGW-1:0] tg, output int lat);
        @(negedge clk);
        mode = m; scale = s; a0 = x0; a1 = x1; tf = t; tag_in = tg; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 16) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (A0 !== '0 || A1 !== '0) $display("FAIL rst_data: got A0=%0d A1=%0d expected 0 0", A0, A1); else n_pass++;
        n_checks++; if (tag_out !== '0) $display("FAIL rst_tag: got %0d expected 0", tag_out); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL post_rst: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); else n_pass++;
    endtask

    task automatic test_dif();
        int lat;
        send_and_wait(MODE_DIF, 1'b0, 17'd5, 17'd3, 17'd2, 8'h11, lat);
        n_checks++; if (lat != BFLY_LAT) $display("FAIL dif_latency: got %0d expected %0d", lat, BFLY_LAT); else n_pass++;
        n_checks++; if (A0 !== 17'd8) $display("FAIL dif_a0: got %0d expected 8", A0); else n_pass++;
        n_checks++; if (A1 !== 17'd4) $display("FAIL dif_a1: got %0d expected 4", A1); else n_pass++;
        n_checks++; if (tag_out !== 8'h11) $display("FAIL dif_tag: got %0h expected 11", tag_out); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL dif_single_delivery: got %b expected 0", out_valid); else n_pass++;

        send_and_wait(MODE_DIF, 1'b0, 17'd3, 17'd5, 17'd1, 8'h12, lat);
        n_checks++; if (lat != BFLY_LAT) $display("FAIL dif_borrow_latency: got %0d expected %0d", lat, BFLY_LAT); else n_pass++;
        n_checks++; if (A0 !== 17'd8) $display("FAIL dif_borrow_a0: got %0d expected 8", A0); else n_pass++;
        n_checks++; if (A1 !== 17'd65535) $display("FAIL dif_borrow_a1: got %0d expected 65535", A1); else n_pass++;

        // Sum wraps past Q: 65536+65536 = 131072 = 65535 mod Q; difference 0.
        send_and_wait(MODE_DIF, 1'b0, 17'd65536, 17'd65536, 17'd7, 8'h13, lat);
        n_checks++; if (A0 !== 17'd65535) $display("FAIL dif_wrap_a0: got %0d expected 65535", A0); else n_pass++;
        n_checks++; if (A1 !== 17'd0) $display("FAIL dif_wrap_a1: got %0d expected 0", A1); else n_pass++;
    endtask

    task automatic test_dit();
        int lat;
        send_and_wait(MODE_DIT, 1'b0, 17'd10, 17'd65536, 17'd65536, 8'h21, lat);
        n_checks++; if (lat != BFLY_LAT) $display("FAIL dit_latency: got %0d expected %0d", lat, BFLY_LAT); else n_pass++;
        n_checks++; if (A0 !== 17'd11) $display("FAIL dit_a0: got %0d expected 11", A0); else n_pass++;
        n_checks++; if (A1 !== 17'd9) $display("FAIL dit_a1: got %0d expected 9", A1); else n_pass++;
        n_checks++; if (tag_out !== 8'h21) $display("FAIL dit_tag: got %0h expected 21", tag_out); else n_pass++;

        // t = 5, a0 - t borrows: 0 - 5 = 65532 mod Q.
        send_and_wait(MODE_DIT, 1'b0, 17'd0, 17'd1, 17'd5, 8'h22, lat);
        n_checks++; if (A0 !== 17'd5) $display("FAIL dit_borrow_a0: got %0d expected 5", A0); else n_pass++;
        n_checks++; if (A1 !== 17'd65532) $display("FAIL dit_borrow_a1: got %0d expected 65532", A1); else n_pass++;
    endtask

    task automatic test_scale();
        int lat;
        logic [LOGQ-1:0] exp_a0;
`ifdef RADIX2_BUTTERFLY_SCALE_EN
        exp_a0 = 17'd1;
`else
        exp_a0 = 17'd2;
`endif
        send_and_wait(MODE_DIF, 1'b1, 17'd1, 17'd1, 17'd1, 8'h31, lat);
        n_checks++; if (lat != BFLY_LAT) $display("FAIL scale_latency: got %0d expected %0d", lat, BFLY_LAT); else n_pass++;
        n_checks++; if (A0 !== exp_a0) $display("FAIL scale_a0: got %0d expected %0d", A0, exp_a0); else n_pass++;
        n_checks++; if (A1 !== 17'd0) $display("FAIL scale_a1: got %0d expected 0", A1); else n_pass++;
    endtask

    // Ten ops, alternating DIF/DIT, one bubble at cycle 3, out_ready low in cycles 6..8.
    task automatic test_back_to_back_stall();
        logic [LOGQ-1:0] exp_a0 [10] = '{17'd20, 17'd23, 17'd24, 17'd29, 17'd28, 17'd35, 17'd32, 17'd41, 17'd36, 17'd47};
        logic [LOGQ-1:0] exp_a1 [10] = '{17'd40, 17'd19, 17'd40, 17'd17, 17'd40, 17'd15, 17'd40, 17'd13, 17'd40, 17'd11};
        logic [LOGQ-1:0] got_a0 [10];
        logic [LOGQ-1:0] got_a1 [10];
        logic [TAGW-1:0] got_tag [10];
        int idx = 0;
        int n_out = 0;
        int n_cmp;
        bit fire_in, fire_out, stalled_seen, extra;
        stalled_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && n_out < 10; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (idx < 10) && (cyc != 3);
            mode      = idx[0];
            scale     = 1'b0;
            a0        = LOGQ'(20 + idx);
            a1        = LOGQ'(idx);
            tf        = 17'd2;
            tag_in    = TAGW'(idx);
            #1;
            if (out_valid && !out_ready) begin
                stalled_seen = 1'b1;
                n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready); else n_pass++;
            end
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (n_out < 10) begin
                    got_a0[n_out] = A0; got_a1[n_out] = A1; got_tag[n_out] = tag_out;
                end
                n_out++;
            end
            if (fire_in) idx++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (!stalled_seen) $display("FAIL stall_observed: got 0 expected 1"); else n_pass++;
        n_checks++; if (idx != 10) $display("FAIL stream_accepted: got %0d expected 10", idx); else n_pass++;
        n_checks++; if (n_out != 10) $display("FAIL stream_delivered: got %0d expected 10", n_out); else n_pass++;
        n_cmp = (n_out < 10) ? n_out : 10;
        for (int k = 0; k < n_cmp; k++) begin
            n_checks++;
            if (got_tag[k] !== TAGW'(k) || got_a0[k] !== exp_a0[k] || got_a1[k] !== exp_a1[k])
                $display("FAIL stream_result_%0d: got tag=%0d A0=%0d A1=%0d expected tag=%0d A0=%0d A1=%0d",
                         k, got_tag[k], got_a0[k], got_a1[k], k, exp_a0[k], exp_a1[k]);
            else n_pass++;
        end
        extra = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) extra = 1'b1;
        end
        n_checks++; if (extra) $display("FAIL stream_no_duplicate: got extra result expected none"); else n_pass++;
    endtask

    // Three ops in flight with the output stalled, then an asynchronous reset.
    task automatic test_reset_midflight();
        int wait_cyc = 0;
        bit stale;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = MODE_DIF; scale = 1'b0; a0 = 17'd100; a1 = 17'd50; tf = 17'd3; tag_in = TAGW'(8'hA5 + i);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && wait_cyc < 16) begin
            @(negedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL pre_rst_stall: got out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready); else n_pass++;
        n_checks++; if (A0 !== 17'd150) $display("FAIL pre_rst_a0: got %0d expected 150", A0); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
        n_checks++; if (A0 !== '0 || A1 !== '0 || tag_out !== '0) $display("FAIL midrst_outputs: got A0=%0d A1=%0d tag=%0d expected 0 0 0", A0, A1, tag_out); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) stale = 1'b1;
        end
        n_checks++; if (stale) $display("FAIL midrst_no_stale: got stale result expected none"); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dif();
        test_dit();
        test_scale();
        test_back_to_back_stall();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
